// File: rtl/recmes_ctrl_sched_if.sv
// ---------------------------------------------------------------------------
// recmes_ctrl_sched_if
// Bundle between the IOCPU/LLC requesters and the receive-message control
// register write scheduler.
//   Requests : cpu_req/cpu_sel/cpu_ofp/cpu_rip/cpu_ien/cpu_ext (IOCPU write)
//              can_req/can_sel/can_rtr/can_dlc (LLC frame stored)
//   Status   : rip_stat[NOBJ] receive-indication bit of every object
//   Strobes  : cpu_we/can_we one-hot per object, cpu_ack/can_ack grants
//   Fields   : ofp/rip/ien/ext (CPU side), ofc/ric/rtr/dlc (CAN side)
//   Stats    : ovf_cnt saturating CAN overflow count
// master = requester side, slave = scheduler.
// ---------------------------------------------------------------------------
interface recmes_ctrl_sched_if #(
  parameter int SELW = 3
);
  localparam int NOBJ = 2 ** SELW;

  logic            cpu_req;
  logic [SELW-1:0] cpu_sel;
  logic            cpu_ofp;
  logic            cpu_rip;
  logic            cpu_ien;
  logic            cpu_ext;
  logic            can_req;
  logic [SELW-1:0] can_sel;
  logic            can_rtr;
  logic [3:0]      can_dlc;
  logic [NOBJ-1:0] rip_stat;

  logic [NOBJ-1:0] cpu_we;
  logic [NOBJ-1:0] can_we;
  logic            ofp;
  logic            rip;
  logic            ien;
  logic            ext;
  logic            ofc;
  logic            ric;
  logic            rtr;
  logic [3:0]      dlc;
  logic            cpu_ack;
  logic            can_ack;
  logic [7:0]      ovf_cnt;

  modport master (
    output cpu_req, cpu_sel, cpu_ofp, cpu_rip, cpu_ien, cpu_ext,
    output can_req, can_sel, can_rtr, can_dlc, rip_stat,
    input  cpu_we, can_we, ofp, rip, ien, ext, ofc, ric, rtr, dlc,
    input  cpu_ack, can_ack, ovf_cnt
  );

  modport slave (
    input  cpu_req, cpu_sel, cpu_ofp, cpu_rip, cpu_ien, cpu_ext,
    input  can_req, can_sel, can_rtr, can_dlc, rip_stat,
    output cpu_we, can_we, ofp, rip, ien, ext, ofc, ric, rtr, dlc,
    output cpu_ack, can_ack, ovf_cnt
  );
endinterface

// File: rtl/recmes_ctrl_sched.sv
// ---------------------------------------------------------------------------
// recmes_ctrl_sched
// Serialises IOCPU and LLC updates of the receive-message control registers
// so that CPU and CAN write strobes never coincide and no request is lost.
// Also derives the CAN-side overflow flag from the target object's current
// receive-indication bit and keeps a saturating overflow count.
// Ports:
//   clk  - clock
//   rst  - synchronous reset, active-low
//   bus  - recmes_ctrl_sched_if.slave (requests, status, strobes, fields)
// All outputs are registered; a request sampled at edge t produces its
// strobe/ack during the cycle following edge t.
// ---------------------------------------------------------------------------
module recmes_ctrl_sched #(
  parameter int SELW = 3
) (
  input logic                 clk,
  input logic                 rst,
  recmes_ctrl_sched_if.slave  bus
);
  localparam int NOBJ = 2 ** SELW;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GNT_CPU = 2'd1,
    S_GNT_CAN = 2'd2
  } state_t;

  localparam logic WIN_CPU = 1'b0;
  localparam logic WIN_CAN = 1'b1;

  state_t          r_state;
  state_t          w_nxt_state;
  logic            r_last_win;
  logic            w_last_win_d;

  logic [NOBJ-1:0] r_cpu_we,  w_cpu_we_d;
  logic [NOBJ-1:0] r_can_we,  w_can_we_d;
  logic            r_cpu_ack, w_cpu_ack_d;
  logic            r_can_ack, w_can_ack_d;
  logic            r_ofp, w_ofp_d;
  logic            r_rip, w_rip_d;
  logic            r_ien, w_ien_d;
  logic            r_ext, w_ext_d;
  logic            r_ofc, w_ofc_d;
  logic            r_ric, w_ric_d;
  logic            r_rtr, w_rtr_d;
  logic [3:0]      r_dlc, w_dlc_d;
  logic [7:0]      r_ovf_cnt, w_ovf_cnt_d;

  function automatic logic [NOBJ-1:0] onehot(input logic [SELW-1:0] sel);
    logic [NOBJ-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_last_win <= WIN_CPU;
    end else begin
      r_state    <= w_nxt_state;
      r_last_win <= w_last_win_d;
    end
  end

  // Next-state logic. Inside a grant the granted requester's own req is
  // ignored: it is still being dropped in response to the ack.
  always_comb begin
    w_nxt_state = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (bus.cpu_req && bus.can_req)
          w_nxt_state = (r_last_win == WIN_CPU) ? S_GNT_CAN : S_GNT_CPU;
        else if (bus.cpu_req)
          w_nxt_state = S_GNT_CPU;
        else if (bus.can_req)
          w_nxt_state = S_GNT_CAN;
        else
          w_nxt_state = S_IDLE;
      end
      S_GNT_CPU: w_nxt_state = bus.can_req ? S_GNT_CAN : S_IDLE;
      S_GNT_CAN: w_nxt_state = bus.cpu_req ? S_GNT_CPU : S_IDLE;
      default:   w_nxt_state = S_IDLE;
    endcase
  end

  // Output logic: computed from the state being entered so the registered
  // strobes line up with the grant cycle. Fields hold unless captured.
  always_comb begin
    w_last_win_d = r_last_win;
    w_cpu_we_d   = '0;
    w_can_we_d   = '0;
    w_cpu_ack_d  = 1'b0;
    w_can_ack_d  = 1'b0;
    w_ofp_d      = r_ofp;
    w_rip_d      = r_rip;
    w_ien_d      = r_ien;
    w_ext_d      = r_ext;
    w_ofc_d      = r_ofc;
    w_ric_d      = r_ric;
    w_rtr_d      = r_rtr;
    w_dlc_d      = r_dlc;
    w_ovf_cnt_d  = r_ovf_cnt;
    case (w_nxt_state)
      S_GNT_CPU: begin
        w_last_win_d = WIN_CPU;
        w_cpu_we_d   = onehot(bus.cpu_sel);
        w_cpu_ack_d  = 1'b1;
        w_ofp_d      = bus.cpu_ofp;
        w_rip_d      = bus.cpu_rip;
        w_ien_d      = bus.cpu_ien;
        w_ext_d      = bus.cpu_ext;
      end
      S_GNT_CAN: begin
        w_last_win_d = WIN_CAN;
        w_can_we_d   = onehot(bus.can_sel);
        w_can_ack_d  = 1'b1;
        w_ric_d      = 1'b1;
        w_rtr_d      = bus.can_rtr;
        w_dlc_d      = bus.can_dlc;
        // A new frame landing on an object whose indication is still set
        // overwrites unread data: that is an overflow.
        w_ofc_d      = bus.rip_stat[bus.can_sel];
        if (bus.rip_stat[bus.can_sel])
          w_ovf_cnt_d = sat_inc8(r_ovf_cnt);
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cpu_we  <= '0;
      r_can_we  <= '0;
      r_cpu_ack <= 1'b0;
      r_can_ack <= 1'b0;
      r_ofp     <= 1'b0;
      r_rip     <= 1'b0;
      r_ien     <= 1'b0;
      r_ext     <= 1'b0;
      r_ofc     <= 1'b0;
      r_ric     <= 1'b0;
      r_rtr     <= 1'b0;
      r_dlc     <= 4'd0;
      r_ovf_cnt <= 8'd0;
    end else begin
      r_cpu_we  <= w_cpu_we_d;
      r_can_we  <= w_can_we_d;
      r_cpu_ack <= w_cpu_ack_d;
      r_can_ack <= w_can_ack_d;
      r_ofp     <= w_ofp_d;
      r_rip     <= w_rip_d;
      r_ien     <= w_ien_d;
      r_ext     <= w_ext_d;
      r_ofc     <= w_ofc_d;
      r_ric     <= w_ric_d;
      r_rtr     <= w_rtr_d;
      r_dlc     <= w_dlc_d;
      r_ovf_cnt <= w_ovf_cnt_d;
    end
  end

  assign bus.cpu_we  = r_cpu_we;
  assign bus.can_we  = r_can_we;
  assign bus.cpu_ack = r_cpu_ack;
  assign bus.can_ack = r_can_ack;
  assign bus.ofp     = r_ofp;
  assign bus.rip     = r_rip;
  assign bus.ien     = r_ien;
  assign bus.ext     = r_ext;
  assign bus.ofc     = r_ofc;
  assign bus.ric     = r_ric;
  assign bus.rtr     = r_rtr;
  assign bus.dlc     = r_dlc;
  assign bus.ovf_cnt = r_ovf_cnt;

endmodule

// File: tb/tb_recmes_ctrl_sched.sv
// ---------------------------------------------------------------------------
// tb_recmes_ctrl_sched
// Directed bench for recmes_ctrl_sched: reset/tie order, lone CPU write,
// continuous contention, overflow flag and count, saturation, reset during
// a CAN grant. Inputs change and outputs are sampled 1 time unit after the
// rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_recmes_ctrl_sched;
  localparam int SELW = 3;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  recmes_ctrl_sched_if #(.SELW(SELW)) bus ();

  recmes_ctrl_sched #(.SELW(SELW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst          = 1'b0;
    bus.cpu_req  = 1'b1;
    bus.cpu_sel  = 3'd0;
    bus.cpu_ofp  = 1'b0;
    bus.cpu_rip  = 1'b0;
    bus.cpu_ien  = 1'b0;
    bus.cpu_ext  = 1'b0;
    bus.can_req  = 1'b1;
    bus.can_sel  = 3'd1;
    bus.can_rtr  = 1'b0;
    bus.can_dlc  = 4'd3;
    bus.rip_stat = 8'h00;

    // Reset held 3 cycles with both requests high
    tick(); tick(); tick();
    chk("rst_cpu_we",  bus.cpu_we,  0);
    chk("rst_can_we",  bus.can_we,  0);
    chk("rst_cpu_ack", bus.cpu_ack, 0);
    chk("rst_can_ack", bus.can_ack, 0);
    chk("rst_fields",  {bus.ofp, bus.rip, bus.ien, bus.ext, bus.ofc, bus.ric, bus.rtr}, 0);
    chk("rst_dlc",     bus.dlc,     0);
    chk("rst_ovf",     bus.ovf_cnt, 0);
    rst = 1'b1;

    // Tie after reset: CAN first
    tick();
    chk("tie_can_ack", bus.can_ack, 1);
    chk("tie_cpu_ack", bus.cpu_ack, 0);
    chk("tie_can_we",  bus.can_we,  32'h02);
    chk("tie_ric",     bus.ric,     1);
    chk("tie_dlc",     bus.dlc,     3);
    bus.can_req = 1'b0;
    tick();
    chk("tie2_cpu_ack", bus.cpu_ack, 1);
    chk("tie2_cpu_we",  bus.cpu_we,  32'h01);
    chk("tie2_can_ack", bus.can_ack, 0);
    bus.cpu_req = 1'b0;
    tick();
    chk("idle_acks", {bus.cpu_ack, bus.can_ack}, 0);
    chk("idle_we",   {bus.cpu_we, bus.can_we}, 0);

    // Lone CPU write, request held one extra cycle
    bus.cpu_sel = 3'd5;
    bus.cpu_ofp = 1'b1;
    bus.cpu_rip = 1'b0;
    bus.cpu_ien = 1'b1;
    bus.cpu_ext = 1'b1;
    bus.cpu_req = 1'b1;
    tick();
    chk("cpu_we",     bus.cpu_we,  32'h20);
    chk("cpu_ack",    bus.cpu_ack, 1);
    chk("cpu_fields", {bus.ofp, bus.rip, bus.ien, bus.ext}, 4'b1011);
    chk("cpu_can_we", bus.can_we,  0);
    tick();
    chk("cpu_hold_we",  bus.cpu_we,  0);
    chk("cpu_hold_ack", bus.cpu_ack, 0);
    bus.cpu_req = 1'b0;
    tick();
    chk("cpu_idle_we",    bus.cpu_we, 0);
    chk("cpu_fields_hold", {bus.ofp, bus.rip, bus.ien, bus.ext}, 4'b1011);

    // Continuous contention: last winner was CPU, so CAN leads
    bus.can_sel = 3'd3;
    bus.cpu_sel = 3'd6;
    bus.cpu_req = 1'b1;
    bus.can_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("cont%0d_can_ack", i), bus.can_ack, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("cont%0d_cpu_ack", i), bus.cpu_ack, (i % 2 == 0) ? 0 : 1);
      chk($sformatf("cont%0d_we", i),      {bus.can_we, bus.cpu_we},
          (i % 2 == 0) ? 32'h0800 : 32'h0040);
      chk($sformatf("cont%0d_overlap", i), bus.cpu_we & bus.can_we, 0);
    end
    bus.cpu_req = 1'b0;
    bus.can_req = 1'b0;
    tick();
    chk("cont_end_acks", {bus.cpu_ack, bus.can_ack}, 0);
    chk("cont_ovf",      bus.ovf_cnt, 0);

    // Overflow: object 2 still indicating a receive
    bus.rip_stat = 8'h04;
    bus.can_sel  = 3'd2;
    bus.can_dlc  = 4'd8;
    bus.can_rtr  = 1'b0;
    bus.can_req  = 1'b1;
    tick();
    chk("ovf_can_we", bus.can_we,  32'h04);
    chk("ovf_ric",    bus.ric,     1);
    chk("ovf_ofc",    bus.ofc,     1);
    chk("ovf_dlc",    bus.dlc,     8);
    chk("ovf_rtr",    bus.rtr,     0);
    chk("ovf_cnt1",   bus.ovf_cnt, 1);
    bus.can_req = 1'b0;
    tick();
    bus.rip_stat = 8'h00;
    bus.can_rtr  = 1'b1;
    bus.can_dlc  = 4'd5;
    bus.can_req  = 1'b1;
    tick();
    chk("noovf_ofc", bus.ofc,     0);
    chk("noovf_cnt", bus.ovf_cnt, 1);
    chk("noovf_rtr", bus.rtr,     1);
    chk("noovf_dlc", bus.dlc,     5);
    bus.can_req = 1'b0;
    tick();

    // Saturation: 260 more overflow grants
    bus.rip_stat = 8'hFF;
    for (int i = 0; i < 260; i++) begin
      bus.can_req = 1'b1;
      tick();
      if (i == 253) chk("sat_cnt255_reached", bus.ovf_cnt, 255);
      bus.can_req = 1'b0;
      tick();
    end
    chk("sat_cnt", bus.ovf_cnt, 255);

    // Reset during a CAN grant
    bus.can_req = 1'b1;
    tick();
    chk("pre_rst_can_ack", bus.can_ack, 1);
    chk("pre_rst_ovf",     bus.ovf_cnt, 255);
    rst = 1'b0;
    tick();
    chk("mid_rst_can_we",  bus.can_we,  0);
    chk("mid_rst_can_ack", bus.can_ack, 0);
    chk("mid_rst_ovf",     bus.ovf_cnt, 0);
    chk("mid_rst_ric",     bus.ric,     0);
    rst = 1'b1;
    bus.can_req = 1'b0;
    tick();
    chk("post_rst_idle", {bus.cpu_ack, bus.can_ack, bus.cpu_we, bus.can_we}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/recmes_ctrl_sched.md
# recmes_ctrl_sched

Write scheduler for the receive-message control registers of all receive message objects. It serialises update requests from the IOCPU write path and the LLC receive path so that, for any object, the CPU and CAN write strobes are never asserted in the same cycle, and no request is lost. It also computes the CAN-side overflow flag from each object's current receive-indication state. It sits between the IOCPU/LLC and the array of per-object control registers, and drives their `cpu`/`can` enables and shared field buses.

## Interface
Parameters:
- SELW, 3, object-select width; number of objects NOBJ = 2**SELW

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- cpu_req  in  1  IOCPU write request, level, held until cpu_ack
- cpu_sel  in  SELW  target object for CPU write
- cpu_ofp, cpu_rip, cpu_ien, cpu_ext  in  1 each  CPU field values
- can_req  in  1  LLC frame-stored request, level, held until can_ack
- can_sel  in  SELW  target object for CAN write
- can_rtr  in  1  remote flag from MAC
- can_dlc  in  4  data length code
- rip_stat  in  NOBJ  current bit 14 (receive indication) of each object register
- cpu_we  out  NOBJ  one-hot CPU write enable
- can_we  out  NOBJ  one-hot CAN write enable
- ofp, rip, ien, ext  out  1 each  registered CPU fields
- ofc, ric, rtr  out  1 each  registered CAN fields
- dlc  out  4  registered DLC
- cpu_ack, can_ack  out  1  one-cycle grant acknowledge
- ovf_cnt  out  8  saturating count of CAN overflows

## Operation
- FSM states: IDLE, GNT_CPU, GNT_CAN. All outputs are registered.
- IDLE:
  - Only cpu_req → GNT_CPU.
  - Only can_req → GNT_CAN.
  - Both → grant the requester that did NOT win last; last_win resets to CPU, so CAN wins the first tie.
- GNT_CPU:
  - cpu_we[cpu_sel]=1 and cpu_ack=1 for this cycle.
  - ofp/rip/ien/ext hold the values captured on entry.
  - last_win=CPU.
  - Next state: GNT_CAN if can_req=1, else IDLE. cpu_req is ignored in this state because the requester is still dropping it.
- GNT_CAN:
  - can_we[can_sel]=1 and can_ack=1.
  - ric=1, rtr and dlc captured on entry.
  - ofc = rip_stat[can_sel] sampled on entry.
  - last_win=CAN.
  - Next state: GNT_CPU if cpu_req=1, else IDLE. can_req is ignored in this state.
- Outside a grant state, all we bits and acks are 0. Field outputs hold their last values.
- ovf_cnt increments on entering GNT_CAN with ofc=1, and saturates at 255.
- Requester rule: a request must drop in the cycle after its ack. A request still high two cycles after its ack is a new request.
- Select and field inputs must be stable while req=1. They are captured on the transition into the grant state.

## Timing
- Reset (rst=0 at posedge) sets:
  - state=IDLE, last_win=CPU
  - all we bits, acks, ofp, rip, ien, ext, ofc, ric, rtr = 0
  - dlc=0, ovf_cnt=0
- Reset mid-grant: strobes and acks are 0 on the next edge, and the pending request is dropped. Requesters must keep req high to be served after reset.
- Latency: req sampled high at edge t → we/ack high during cycle t+1 (one cycle).
- Throughput:
  - One requester alone: one grant every 2 cycles.
  - Both continuously requesting: grants alternate CPU/CAN every cycle, with no idle cycle between them.
- cpu_we & can_we is never nonzero in the same cycle.
- Same-object back-to-back (CAN then CPU): the CPU write is granted the cycle after the CAN strobe. rip_stat then reflects the CAN update for any later CAN grant.

## Test plan
- Reset: hold rst=0 for 3 cycles with both reqs high → all outputs 0. Release → can_ack first (tie rule), cpu_ack on the next cycle.
- Lone CPU: cpu_sel=5, ofp=1, rip=0, ien=1, ext=1 → one cycle later cpu_we=8'h20, ofp=1, ien=1, ext=1, cpu_ack=1. Holding req one more cycle produces no second strobe.
- Contention: both reqs held continuously for 10 cycles, re-asserted right after each ack → acks alternate CAN, CPU, CAN…; cpu_we and can_we never overlap.
- Overflow: rip_stat[2]=1, can_sel=2, dlc=8, rtr=0 → can_we=8'h04, ric=1, ofc=1, dlc=8, ovf_cnt=1. With rip_stat[2]=0 → ofc=0 and the count is unchanged.
- Saturation: 260 overflow grants → ovf_cnt=255.
- Reset during GNT_CAN → next cycle can_we=0, can_ack=0, ovf_cnt=0, state IDLE.
